// File: rtl/mult_share_arb.sv
// mult_share_arb
// Shares one 4-bit signed fixed-point multiplier among NUM_REQ requesters.
// Requesters are served in round-robin order. Each result is tagged with the
// ID of its requester and returned over a valid/ready output channel.
// result = bits [7:4] of op1 * op2, with both operands sign-extended first.
// The result is truncated: no rounding, no saturation.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both high. req_ready is combinational from
// req_valid, state and rr_ptr only, and is never driven by out_ready.
// out_valid, out_result and out_id are registered. They hold stable until
// out_ready is seen high.
//
// Optional build macro MULT_SHARE_ARB_STATS_EN adds saturating 16-bit
// counters:
//   busy_cnt  - cycles spent outside IDLE
//   stall_cnt - DONE cycles with out_ready low
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   req_valid   per-requester operand-pair valid      [NUM_REQ]
//   req_ready   per-requester accept, one-hot or zero [NUM_REQ]
//   req_op1     packed operand 1, slice i = [4i+3:4i]
//   req_op2     packed operand 2, same packing
//   out_valid   result valid
//   out_ready   downstream accept
//   out_result  product bits [7:4]
//   out_id      owner requester index
module mult_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_op1,
  input  logic [4*NUM_REQ-1:0] req_op2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_result,
  output logic [ID_W-1:0]      out_id
`ifdef MULT_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]          busy_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     id_q;
  logic [3:0]          op1_q;
  logic [3:0]          op2_q;

  logic [ID_W-1:0]     winner;
  logic                any_valid;
  logic [ID_W:0]       scan_sum;
  logic [ID_W-1:0]     scan_idx;
  logic [3:0]          win_op1;
  logic [3:0]          win_op2;

  logic signed [15:0]  op1_ext;
  logic signed [15:0]  op2_ext;
  logic signed [15:0]  product;

  // Round-robin scan: visit rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  // The first valid requester found wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        winner    = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign win_op1 = req_op1[4*int'(winner) +: 4];
  assign win_op2 = req_op2[4*int'(winner) +: 4];

  // Sign-extending to 16 bits gives the same low byte as an 8x8 signed
  // product, so bits [7:4] are unaffected by the wider extension.
  assign op1_ext = 16'(signed'(op1_q));
  assign op2_ext = 16'(signed'(op2_q));
  assign product = op1_ext * op2_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op1_q <= win_op1;
            op2_q <= win_op2;
            id_q  <= winner;
            if (winner == ID_W'(NUM_REQ-1)) rr_ptr <= '0;
            else                            rr_ptr <= winner + 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          out_result <= product[7:4];
          out_id     <= id_q;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state != IDLE && busy_cnt != 16'hFFFF) begin
        busy_cnt <= busy_cnt + 16'd1;
      end
      if (state == DONE && !out_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb.
// Directed vectors with hand-computed results. A scoreboard queue holds the
// expected {id, result} pairs, and a monitor pops them on output transfers.
module tb_mult_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_op1 = '0;
  logic [4*NUM_REQ-1:0] req_op2 = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [3:0]           out_result;
  logic [ID_W-1:0]      out_id;
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [15:0]          busy_cnt;
  logic [15:0]          stall_cnt;
  logic [15:0]          busy_s;
  logic [15:0]          stall_s;
`endif

  logic [ID_W+3:0] exp_q[$];
  logic [ID_W+3:0] mon_exp;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mult_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_id     (out_id)
`ifdef MULT_SHARE_ARB_STATS_EN
    ,
    .busy_cnt   (busy_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Inputs only change just after posedge, so out_ready seen here is the
  // value at the next edge, where the transfer actually happens.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d res=%b, nothing expected", out_id, out_result);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result_id_res", 32'({out_id, out_result}), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request from requester id while the others are idle.
  // Returns at the negedge of the first DONE cycle.
  task automatic send(input int id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
    int budget;
    @(posedge clk); #1;
    req_op1[id*4 +: 4] = a;
    req_op2[id*4 +: 4] = b;
    req_valid[id]      = 1'b1;
    budget = 0;
    @(negedge clk);
    while (req_ready[id] !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("grant_onehot", 32'(req_ready), 32'(1) << id);
    if (req_ready[id] === 1'b1) exp_q.push_back({ID_W'(id), r});
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("mul_cycle_valid_low", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_valid_high", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] rr_a [NUM_REQ];
  logic [3:0] rr_b [NUM_REQ];
  logic [3:0] rr_r [NUM_REQ];
  int last_cyc;
  int budget;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requests: 6*4=24=0x18 -> 1; -2*6=-12=0xF4 -> F; -8*-8=64=0x40 -> 4
    out_ready = 1'b1;
    send(1, 4'b0110, 4'b0100, 4'b0001);
    send(0, 4'b1110, 4'b0110, 4'b1111);
    send(2, 4'b1000, 4'b1000, 4'b0100);

    // Backpressure: 7*7=49=0x31 -> 3, held for 5 stalled DONE cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifdef MULT_SHARE_ARB_STATS_EN
    busy_s  = busy_cnt;
    stall_s = stall_cnt;
`endif
    send(3, 4'b0111, 4'b0111, 4'b0011);
    req_op1[3:0] = 4'b0001;
    req_op2[3:0] = 4'b0001;
    req_valid[0] = 1'b1;  // must not be granted while busy
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_result_held", 32'(out_result), 32'b0011);
      chk("bp_id_held", 32'(out_id), 32'd3);
      chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;  // dropped before any grant: skipped
    out_ready    = 1'b1;
    @(posedge clk); #1;
    chk("bp_complete_valid_low", 32'(out_valid), 32'd0);
`ifdef MULT_SHARE_ARB_STATS_EN
    chk("stats_busy_delta", 32'(busy_cnt - busy_s), 32'd7);
    chk("stats_stall_delta", 32'(stall_cnt - stall_s), 32'd5);
`endif
    drain();

    // Round robin with all requesters valid, rr_ptr at 0 after requester 3.
    // 5*-3=-15=0xF1->F, 7*-8=-56=0xC8->C, 6*6=36=0x24->2, 2*-5=-10=0xF6->F
    rr_a[0] = 4'b0101; rr_b[0] = 4'b1101; rr_r[0] = 4'hF;
    rr_a[1] = 4'b0111; rr_b[1] = 4'b1000; rr_r[1] = 4'hC;
    rr_a[2] = 4'b0110; rr_b[2] = 4'b0110; rr_r[2] = 4'h2;
    rr_a[3] = 4'b0010; rr_b[3] = 4'b1011; rr_r[3] = 4'hF;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op1[i*4 +: 4] = rr_a[i];
      req_op2[i*4 +: 4] = rr_b[i];
    end
    req_valid = '1;
    last_cyc  = 0;
    for (int g = 0; g < 2*NUM_REQ; g++) begin
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (req_ready == '0 && budget < 20);
      chk("rr_grant_order", 32'(req_ready), 32'(1) << (g % NUM_REQ));
      if (g > 0) chk("rr_interval", 32'(cyc - last_cyc), 32'd3);
      last_cyc = cyc;
      exp_q.push_back({ID_W'(g % NUM_REQ), rr_r[g % NUM_REQ]});
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Reset while in DONE: rr_ptr is 0, requester 2 is granted, rr_ptr -> 3.
    out_ready = 1'b0;
    send(2, 4'b0110, 4'b0110, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid_low", 32'(out_valid), 32'd0);
    chk("rst_async_result_zero", 32'(out_result), 32'd0);
    exp_q.delete();
    // 4*4=16=0x10 -> 1; requester 3 would win without the rr_ptr reset
    req_op1[3:0]   = 4'b0100;
    req_op2[3:0]   = 4'b0100;
    req_op1[15:12] = 4'b0011;
    req_op2[15:12] = 4'b0011;
    req_valid      = 4'b1001;
    out_ready      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (req_ready == '0 && budget < 20);
    chk("post_rst_grant_req0", 32'(req_ready), 32'b0001);
    exp_q.push_back({ID_W'(0), 4'b0001});
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
